pipe_hazard_ctrl: RTL and testbench

- Hazard and pipeline-control unit for the 5-stage IF/ID/EX/MEM/WB datapath of the RSA decryption ASIP.
- Generates EX operand-forwarding selects, load-use stalls, taken-branch flushes and multicycle-EX holds, so the datapath can execute back-to-back dependent instructions and long modular-arithmetic ops without compiler-inserted NOPs.
- Sits beside the datapath top; consumes pipe-register addresses and control bits, and drives stall/flush/enable inputs of the pipe registers.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/fwd_unit.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RSA ASIP pipeline hazard/control unit.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source operand; MEM ALU result beats WB data.
module fwd_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned RW       = 5,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic [RW-1:0] src,
   input  logic [RW-1:0] rw_mem,
   input  logic [RW-1:0] rw_wb,
   input  logic          wr_en_mem,
   input  logic          wd_sel_mem,
   input  logic          wr_en_wb,
   output fwd_sel_t      sel
);

   function automatic logic reg_match(input logic [RW-1:0] x, input logic [RW-1:0] y);
      return (x == y) && !(ZERO_REG && (y == '0));
   endfunction

   // A load still in MEM has no data yet, so only ALU results forward from MEM.
   always_comb begin
      sel = FWD_REG;
      if (wr_en_mem && !wd_sel_mem && reg_match(src, rw_mem)) begin
         sel = FWD_MEM;
      end else if (wr_en_wb && reg_match(src, rw_wb)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: forwarding, load-use stalls, branch flushes,
// multicycle-EX holds with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned RW       = 5,
   parameter int unsigned CW       = 16,
   parameter int unsigned MC_MAX   = 64,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [RW-1:0] ra_id,
   input  logic [RW-1:0] rb_id,
   input  logic [RW-1:0] ra_ex,
   input  logic [RW-1:0] rb_ex,
   input  logic [RW-1:0] rw_ex,
   input  logic [RW-1:0] rw_mem,
   input  logic [RW-1:0] rw_wb,
   input  logic          wr_en_ex,
   input  logic          wr_en_mem,
   input  logic          wr_en_wb,
   input  logic          wd_sel_ex,
   input  logic          wd_sel_mem,
   input  logic          branch_taken,
   input  logic          mc_start,
   input  logic          mc_done,
   output logic          pc_stall,
   output logic          ifid_stall,
   output logic          idex_hold,
   output logic          idex_bubble,
   output logic          ifid_flush,
   output logic          idex_flush,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b,
   output logic          busy,
   output logic          mc_err,
   output logic [CW-1:0] stall_cnt,
   output logic [CW-1:0] flush_cnt
);

   localparam int unsigned TW = $clog2(MC_MAX + 1);

   state_t        state;
   logic [TW-1:0] tmo;
   logic          lu;
   logic          mc_stall;
   fwd_sel_t      sel_a;
   fwd_sel_t      sel_b;

   function automatic logic reg_match(input logic [RW-1:0] x, input logic [RW-1:0] y);
      return (x == y) && !(ZERO_REG && (y == '0));
   endfunction

   fwd_unit #(.RW(RW), .ZERO_REG(ZERO_REG)) u_fwd_a (
      .src(ra_ex), .rw_mem(rw_mem), .rw_wb(rw_wb), .wr_en_mem(wr_en_mem),
      .wd_sel_mem(wd_sel_mem), .wr_en_wb(wr_en_wb), .sel(sel_a)
   );

   fwd_unit #(.RW(RW), .ZERO_REG(ZERO_REG)) u_fwd_b (
      .src(rb_ex), .rw_mem(rw_mem), .rw_wb(rw_wb), .wr_en_mem(wr_en_mem),
      .wd_sel_mem(wd_sel_mem), .wr_en_wb(wr_en_wb), .sel(sel_b)
   );

   assign fwd_a = reset ? FWD_REG : sel_a;
   assign fwd_b = reset ? FWD_REG : sel_b;

   // Pipe-register controls; priority reset > multicycle > branch > load-use.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_hold   = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      busy        = 1'b0;
      lu          = wr_en_ex && wd_sel_ex &&
                    (reg_match(ra_id, rw_ex) || reg_match(rb_id, rw_ex));
      mc_stall    = (state == MC_WAIT) ? !mc_done : (mc_start && !mc_done);
      if (reset) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (state == MC_WAIT) begin
         pc_stall   = mc_stall;
         ifid_stall = mc_stall;
         idex_hold  = mc_stall;
         busy       = mc_stall;
      end else if (mc_stall) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_hold  = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RUN;
         tmo       <= '0;
         mc_err    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mc_start && !mc_done) begin
                  state <= MC_WAIT;
                  tmo   <= TW'(1);
               end
            end
            MC_WAIT: begin
               if (mc_done) begin
                  state <= RUN;
               end else if (tmo == TW'(MC_MAX)) begin
                  state  <= RUN;
                  mc_err <= 1'b1;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            default: state <= RUN;
         endcase
         if (pc_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CW'(1);
         end
         if (ifid_flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default instance and a small one (CW=2, MC_MAX=4)
// share directed stimulus and are checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int unsigned RW = 5;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic [RW-1:0] ra_id, rb_id, ra_ex, rb_ex, rw_ex, rw_mem, rw_wb;
   logic          wr_en_ex, wr_en_mem, wr_en_wb, wd_sel_ex, wd_sel_mem;
   logic          branch_taken, mc_start, mc_done;

   logic pc_stall_o [2], ifid_stall_o [2], idex_hold_o [2], idex_bubble_o [2];
   logic ifid_flush_o [2], idex_flush_o [2], busy_o [2], mc_err_o [2];
   logic [1:0]  fwd_a_o [2], fwd_b_o [2];
   logic [15:0] sc_big, fc_big;
   logic [1:0]  sc_sm, fc_sm;

   int n_total = 0;
   int n_bad   = 0;
   bit run_chk = 1'b0;

   pipe_hazard_ctrl u_big (
      .clock(clock), .reset(reset), .ra_id(ra_id), .rb_id(rb_id), .ra_ex(ra_ex), .rb_ex(rb_ex),
      .rw_ex(rw_ex), .rw_mem(rw_mem), .rw_wb(rw_wb), .wr_en_ex(wr_en_ex), .wr_en_mem(wr_en_mem),
      .wr_en_wb(wr_en_wb), .wd_sel_ex(wd_sel_ex), .wd_sel_mem(wd_sel_mem),
      .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
      .pc_stall(pc_stall_o[0]), .ifid_stall(ifid_stall_o[0]), .idex_hold(idex_hold_o[0]),
      .idex_bubble(idex_bubble_o[0]), .ifid_flush(ifid_flush_o[0]), .idex_flush(idex_flush_o[0]),
      .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]), .busy(busy_o[0]), .mc_err(mc_err_o[0]),
      .stall_cnt(sc_big), .flush_cnt(fc_big)
   );

   pipe_hazard_ctrl #(.RW(RW), .CW(2), .MC_MAX(4), .ZERO_REG(1'b1)) u_sm (
      .clock(clock), .reset(reset), .ra_id(ra_id), .rb_id(rb_id), .ra_ex(ra_ex), .rb_ex(rb_ex),
      .rw_ex(rw_ex), .rw_mem(rw_mem), .rw_wb(rw_wb), .wr_en_ex(wr_en_ex), .wr_en_mem(wr_en_mem),
      .wr_en_wb(wr_en_wb), .wd_sel_ex(wd_sel_ex), .wd_sel_mem(wd_sel_mem),
      .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
      .pc_stall(pc_stall_o[1]), .ifid_stall(ifid_stall_o[1]), .idex_hold(idex_hold_o[1]),
      .idex_bubble(idex_bubble_o[1]), .ifid_flush(ifid_flush_o[1]), .idex_flush(idex_flush_o[1]),
      .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]), .busy(busy_o[1]), .mc_err(mc_err_o[1]),
      .stall_cnt(sc_sm), .flush_cnt(fc_sm)
   );

   // Behavioural model: per instance, "waiting" flag, cycles spent, error, event counts.
   int m_cap [2] = '{65535, 3};
   int m_max [2] = '{64, 4};
   bit m_wait [2];
   int m_elapsed [2];
   bit m_err [2];
   int m_sn [2];
   int m_fn [2];

   typedef struct packed {
      bit stall; bit hold; bit bubble; bit flush; bit busy; int fa; int fb;
   } exp_t;

   function automatic bit hits(input logic [RW-1:0] x, input logic [RW-1:0] y);
      return (x == y) && (y != 0);
   endfunction

   function automatic int fwd_of(input logic [RW-1:0] src);
      if (reset) return 0;
      if (wr_en_mem && !wd_sel_mem && hits(src, rw_mem)) return 1;
      if (wr_en_wb && hits(src, rw_wb)) return 2;
      return 0;
   endfunction

   function automatic exp_t expect_of(input int i);
      exp_t e;
      bit hold, lu;
      hold     = m_wait[i] ? !mc_done : (mc_start && !mc_done);
      lu       = wr_en_ex && wd_sel_ex && (hits(ra_id, rw_ex) || hits(rb_id, rw_ex));
      e.flush  = reset || (!m_wait[i] && !hold && branch_taken);
      e.bubble = !reset && !m_wait[i] && !hold && !branch_taken && lu;
      e.hold   = !reset && hold;
      e.stall  = e.hold || e.bubble;
      e.busy   = !reset && m_wait[i] && !mc_done;
      e.fa     = fwd_of(ra_ex);
      e.fb     = fwd_of(rb_ex);
      return e;
   endfunction

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         e = expect_of(i);
         if (reset) begin
            m_wait[i] = 1'b0; m_elapsed[i] = 0; m_err[i] = 1'b0; m_sn[i] = 0; m_fn[i] = 0;
         end else begin
            if (e.stall && m_sn[i] < m_cap[i]) m_sn[i]++;
            if (e.flush && m_fn[i] < m_cap[i]) m_fn[i]++;
            if (!m_wait[i]) begin
               if (mc_start && !mc_done) begin m_wait[i] = 1'b1; m_elapsed[i] = 1; end
            end else if (mc_done) begin
               m_wait[i] = 1'b0;
            end else if (m_elapsed[i] >= m_max[i]) begin
               m_wait[i] = 1'b0; m_err[i] = 1'b1;
            end else begin
               m_elapsed[i]++;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (run_chk) begin
         for (int i = 0; i < 2; i++) begin
            exp_t e;
            e = expect_of(i);
            chk($sformatf("pc_stall[%0d]", i), 32'(pc_stall_o[i]), int'(e.stall));
            chk($sformatf("ifid_stall[%0d]", i), 32'(ifid_stall_o[i]), int'(e.stall));
            chk($sformatf("idex_hold[%0d]", i), 32'(idex_hold_o[i]), int'(e.hold));
            chk($sformatf("idex_bubble[%0d]", i), 32'(idex_bubble_o[i]), int'(e.bubble));
            chk($sformatf("ifid_flush[%0d]", i), 32'(ifid_flush_o[i]), int'(e.flush));
            chk($sformatf("idex_flush[%0d]", i), 32'(idex_flush_o[i]), int'(e.flush));
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), int'(e.busy));
            chk($sformatf("fwd_a[%0d]", i), 32'(fwd_a_o[i]), e.fa);
            chk($sformatf("fwd_b[%0d]", i), 32'(fwd_b_o[i]), e.fb);
            chk($sformatf("mc_err[%0d]", i), 32'(mc_err_o[i]), int'(m_err[i]));
            chk($sformatf("stall_cnt[%0d]", i), (i == 0) ? 32'(sc_big) : 32'(sc_sm), m_sn[i]);
            chk($sformatf("flush_cnt[%0d]", i), (i == 0) ? 32'(fc_big) : 32'(fc_sm), m_fn[i]);
         end
      end
   end

   task automatic idle();
      ra_id = '0; rb_id = '0; ra_ex = '0; rb_ex = '0; rw_ex = '0; rw_mem = '0; rw_wb = '0;
      wr_en_ex = 1'b0; wr_en_mem = 1'b0; wr_en_wb = 1'b0; wd_sel_ex = 1'b0; wd_sel_mem = 1'b0;
      branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_use_r7();
      wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rw_ex = 5'd7; rb_id = 5'd7;
   endtask

   initial begin
      // Reset with a live MEM match: forwarding must still read 00.
      idle(); reset = 1'b1;
      wr_en_mem = 1'b1; rw_mem = 5'd3; ra_ex = 5'd3;
      tick(); run_chk = 1'b1;
      @(negedge clock);
      chk("lit_rst_flush", 32'(ifid_flush_o[0]), 1);
      chk("lit_rst_fwd_a", 32'(fwd_a_o[0]), 0);
      chk("lit_rst_stall_cnt", 32'(sc_big), 0);

      // ALU chain forwarding
      tick(); reset = 1'b0;
      @(negedge clock);
      chk("lit_fwd_mem", 32'(fwd_a_o[0]), 1);
      tick(); wr_en_wb = 1'b1; rw_wb = 5'd3; rb_ex = 5'd3;
      @(negedge clock);
      chk("lit_fwd_mem_over_wb", 32'(fwd_a_o[0]), 1);
      tick(); wr_en_mem = 1'b0;
      @(negedge clock);
      chk("lit_fwd_wb", 32'(fwd_a_o[0]), 2);
      tick(); wr_en_mem = 1'b1; rw_mem = 5'd0; rw_wb = 5'd0; ra_ex = 5'd0; rb_ex = 5'd0;
      @(negedge clock);
      chk("lit_fwd_r0", 32'(fwd_a_o[0]), 0);
      tick(); wd_sel_mem = 1'b1; rw_mem = 5'd4; rw_wb = 5'd4; ra_ex = 5'd4;
      @(negedge clock);
      chk("lit_fwd_load_mem_wb", 32'(fwd_a_o[0]), 2);

      // Load-use on r7, then the consumer takes r7 from WB
      tick(); idle(); load_use_r7();
      @(negedge clock);
      chk("lit_lu_stall", 32'(pc_stall_o[0]), 1);
      chk("lit_lu_bubble", 32'(idex_bubble_o[0]), 1);
      tick(); idle(); rb_ex = 5'd7; wr_en_wb = 1'b1; rw_wb = 5'd7;
      @(negedge clock);
      chk("lit_lu_fwd_b", 32'(fwd_b_o[0]), 2);
      chk("lit_lu_stall_cnt", 32'(sc_big), 1);
      tick(); idle(); wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rw_ex = 5'd0; ra_id = 5'd0;

      // Branch and load-use together: flush wins
      tick(); idle(); load_use_r7(); branch_taken = 1'b1;
      @(negedge clock);
      chk("lit_br_flush", 32'(idex_flush_o[0]), 1);
      chk("lit_br_bubble", 32'(idex_bubble_o[0]), 0);
      chk("lit_br_pc_stall", 32'(pc_stall_o[0]), 0);
      tick(); idle();
      @(negedge clock);
      chk("lit_br_flush_cnt", 32'(fc_big), 1);
      // Single-cycle multicycle op: no stall, branch still acts
      tick(); mc_start = 1'b1; mc_done = 1'b1; branch_taken = 1'b1;
      tick(); idle(); reset = 1'b1;

      // Multicycle: start at 0, done at 5; small instance times out after 4 waits
      tick(); reset = 1'b0; mc_start = 1'b1;
      @(negedge clock);
      chk("lit_mc0_hold", 32'(idex_hold_o[0]), 1);
      chk("lit_mc0_busy", 32'(busy_o[0]), 0);
      for (int c = 1; c <= 4; c++) begin
         tick(); idle();
      end
      tick(); mc_done = 1'b1;
      @(negedge clock);
      chk("lit_mc5_stall", 32'(pc_stall_o[0]), 0);
      chk("lit_mc5_busy", 32'(busy_o[0]), 0);
      chk("lit_sm_err", 32'(mc_err_o[1]), 1);
      tick(); idle();
      @(negedge clock);
      chk("lit_mc_stall_cnt", 32'(sc_big), 5);
      chk("lit_sm_stall_sat", 32'(sc_sm), 3);

      // Timeout without done; branch ignored while waiting; reset mid-wait
      tick(); mc_start = 1'b1;
      tick(); idle();
      tick(); branch_taken = 1'b1;
      @(negedge clock);
      chk("lit_wait_no_flush", 32'(ifid_flush_o[0]), 0);
      tick(); idle();
      tick();
      tick();
      @(negedge clock);
      chk("lit_sm_err_sticky", 32'(mc_err_o[1]), 1);
      chk("lit_big_still_busy", 32'(busy_o[0]), 1);
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      @(negedge clock);
      chk("lit_rst_wait_busy", 32'(busy_o[0]), 0);
      chk("lit_rst_wait_stall", 32'(pc_stall_o[0]), 0);
      chk("lit_rst_wait_cnt", 32'(sc_big), 0);
      chk("lit_rst_sm_err", 32'(mc_err_o[1]), 0);
      tick();
      @(negedge clock);
      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
